// File: rtl/tlb_pkg.sv
// Shared types for the IMMU TLB: sizing, maintenance opcodes, controller
// state encoding, the entry layout and the PID-invalidate match rule.
package tlb_pkg;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_INV_ALL = 2'b10,
    OP_INV_PID = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_SWEEP = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;

  // PERMIS bit positions, MSB first: UX,UW,UR,SX,SW,SR
  localparam int PERMIS_SR = 0;
  localparam int PERMIS_SW = 1;
  localparam int PERMIS_SX = 2;
  localparam int PERMIS_UR = 3;
  localparam int PERMIS_UW = 4;
  localparam int PERMIS_UX = 5;

  typedef struct packed {
    logic        V;
    logic        TS;
    logic [7:0]  TID;
    logic [31:0] EPN;
    logic [31:0] RPN;
    logic [5:0]  PERMIS;
  } tlb_entry_t;

  // An entry is dropped by INV_PID when it is valid and belongs to the
  // requested PID/TS. Global entries (TID==0) only go when PID 0 is targeted.
  function automatic logic pid_match(input tlb_entry_t e, input logic [7:0] tid,
                                     input logic ts);
    return e.V && (e.TID == tid) && (e.TS == ts) &&
           ((e.TID != 8'h00) || (tid == 8'h00));
  endfunction

endpackage

// File: rtl/tlb_entry_array.sv
// TLB entry register file: full-entry write port, V-clear port, a
// maintenance read port (captured by the controller) and the hit-judge
// lookup read port. Contents clear asynchronously on reset.
module tlb_entry_array
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  tlb_entry_t       i_wr_data,
  input  logic             i_clr_en,
  input  logic [IDX_W-1:0] i_clr_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output tlb_entry_t       o_rd_data,
  input  logic [IDX_W-1:0] i_lk_idx,
  output tlb_entry_t       o_lk_data
);

  tlb_entry_t r_mem [ENTRIES];

  // Storage update: full-entry write and V-only clear (never both at once).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_mem[i] <= '0;
    end else begin
      if (i_wr_en)  r_mem[i_wr_idx]   <= i_wr_data;
      if (i_clr_en) r_mem[i_clr_idx].V <= 1'b0;
    end
  end

  // No write bypass: readers see the pre-edge contents.
  assign o_rd_data = r_mem[i_rd_idx];
  assign o_lk_data = r_mem[i_lk_idx];

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance controller: accepts WRITE/READ/INV_ALL/INV_PID requests,
// owns the entry array and drives the hit-judge lookup port and stall flag.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE. All req_* fields
// are latched at that edge, so the requester may change them afterwards.
module tlb_maint_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = tlb_pkg::ENTRIES,
  parameter int IDX_W   = tlb_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic             req_V,
  input  logic             req_TS,
  input  logic [7:0]       req_TID,
  input  logic [31:0]      req_EPN,
  input  logic [31:0]      req_RPN,
  input  logic [5:0]       req_PERMIS,
  output logic             done,
  output logic             rsp_V,
  output logic             rsp_TS,
  output logic [7:0]       rsp_TID,
  output logic [31:0]      rsp_EPN,
  output logic [31:0]      rsp_RPN,
  output logic [5:0]       rsp_PERMIS,
  input  logic [IDX_W-1:0] lk_index,
  output logic             TLB_entry_V,
  output logic             TLB_entry_TS,
  output logic [7:0]       TLB_entry_TID,
  output logic [31:0]      TLB_entry_EPN,
  output logic [31:0]      TLB_entry_RPN,
  output logic [5:0]       TLB_entry_PERMIS,
  output logic             lookup_stall,
  output tlb_state_e       dbg_state
);

  tlb_state_e       r_state;
  tlb_op_e          r_op;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  tlb_entry_t       r_ent;
  tlb_entry_t       r_rsp;
  logic             r_done;
  logic             r_stall;

  logic             w_wr_en;
  logic             w_clr_en;
  logic [IDX_W-1:0] w_rd_idx;
  tlb_entry_t       w_rd_data;
  tlb_entry_t       w_lk_data;

  // During a sweep the maintenance read port follows the sweep counter so
  // the clear decision is made on the current (pre-clear) entry.
  assign w_rd_idx = (r_state == ST_SWEEP) ? r_cnt : r_idx;
  assign w_wr_en  = (r_state == ST_WRITE);
  assign w_clr_en = (r_state == ST_SWEEP) &&
                    ((r_op == OP_INV_ALL) || pid_match(w_rd_data, r_ent.TID, r_ent.TS));

  tlb_entry_array #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_data (r_ent),
    .i_clr_en  (w_clr_en),
    .i_clr_idx (r_cnt),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_lk_idx  (lk_index),
    .o_lk_data (w_lk_data)
  );

  // Maintenance FSM with latched request, sweep counter and response regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_WRITE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_ent   <= '0;
      r_rsp   <= '0;
      r_done  <= 1'b0;
      r_stall <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op  <= tlb_op_e'(req_op);
            r_idx <= req_index;
            r_ent <= {req_V, req_TS, req_TID, req_EPN, req_RPN, req_PERMIS};
            unique case (tlb_op_e'(req_op))
              OP_WRITE: r_state <= ST_WRITE;
              OP_READ:  r_state <= ST_READ;
              default: begin
                r_cnt   <= '0;
                r_stall <= 1'b1;
                r_state <= ST_SWEEP;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_READ: begin
          r_rsp   <= w_rd_data;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_SWEEP: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(ENTRIES - 1)) begin
            r_stall <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rsp   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign done         = r_done;
  assign lookup_stall = r_stall;
  assign dbg_state    = r_state;

  assign rsp_V      = r_rsp.V;
  assign rsp_TS     = r_rsp.TS;
  assign rsp_TID    = r_rsp.TID;
  assign rsp_EPN    = r_rsp.EPN;
  assign rsp_RPN    = r_rsp.RPN;
  assign rsp_PERMIS = r_rsp.PERMIS;

  assign TLB_entry_V      = w_lk_data.V;
  assign TLB_entry_TS     = w_lk_data.TS;
  assign TLB_entry_TID    = w_lk_data.TID;
  assign TLB_entry_EPN    = w_lk_data.EPN;
  assign TLB_entry_RPN    = w_lk_data.RPN;
  assign TLB_entry_PERMIS = w_lk_data.PERMIS;

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Bench for tlb_maint_ctrl: directed scenarios plus random maintenance
// traffic against an array-based reference model, with a scoreboard queue
// checked by an independent done monitor.
module tb_tlb_maint_ctrl;
  import tlb_pkg::*;

  localparam int W = 120;  // {stall cycles[8], done cycle[32], rsp entry[80]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- DUT ----------------
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_index, lk_index;
  logic        req_V, req_TS;
  logic [7:0]  req_TID;
  logic [31:0] req_EPN, req_RPN;
  logic [5:0]  req_PERMIS;
  logic        done, lookup_stall;
  logic        rsp_V, rsp_TS;
  logic [7:0]  rsp_TID;
  logic [31:0] rsp_EPN, rsp_RPN;
  logic [5:0]  rsp_PERMIS;
  logic        TLB_entry_V, TLB_entry_TS;
  logic [7:0]  TLB_entry_TID;
  logic [31:0] TLB_entry_EPN, TLB_entry_RPN;
  logic [5:0]  TLB_entry_PERMIS;
  tlb_state_e  dbg_state;

  tlb_maint_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_V(req_V), .req_TS(req_TS), .req_TID(req_TID),
    .req_EPN(req_EPN), .req_RPN(req_RPN), .req_PERMIS(req_PERMIS),
    .done(done),
    .rsp_V(rsp_V), .rsp_TS(rsp_TS), .rsp_TID(rsp_TID), .rsp_EPN(rsp_EPN),
    .rsp_RPN(rsp_RPN), .rsp_PERMIS(rsp_PERMIS),
    .lk_index(lk_index),
    .TLB_entry_V(TLB_entry_V), .TLB_entry_TS(TLB_entry_TS),
    .TLB_entry_TID(TLB_entry_TID), .TLB_entry_EPN(TLB_entry_EPN),
    .TLB_entry_RPN(TLB_entry_RPN), .TLB_entry_PERMIS(TLB_entry_PERMIS),
    .lookup_stall(lookup_stall), .dbg_state(dbg_state)
  );

  // ---------------- reference model + scoreboard ----------------
  tlb_entry_t     mdl [16];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tlb_entry_t mk(input logic v, input logic ts, input logic [7:0] tid,
                                    input logic [31:0] epn, input logic [31:0] rpn,
                                    input logic [5:0] perm);
    tlb_entry_t e;
    e.V = v; e.TS = ts; e.TID = tid; e.EPN = epn; e.RPN = rpn; e.PERMIS = perm;
    return e;
  endfunction

  function automatic tlb_entry_t rnd_entry();
    logic [7:0] tids [3];
    tids[0] = 8'h00; tids[1] = 8'h12; tids[2] = 8'h34;
    return mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              tids[$urandom_range(0, 2)], $urandom, $urandom, 6'($urandom_range(0, 63)));
  endfunction

  // Apply one accepted op to the model; returns the READ data (else zero).
  function automatic tlb_entry_t model_apply(input logic [1:0] op, input int idx,
                                             input tlb_entry_t ent);
    tlb_entry_t r;
    r = '0;
    case (op)
      2'b00: mdl[idx] = ent;
      2'b01: r = mdl[idx];
      2'b10: for (int i = 0; i < 16; i++) mdl[i].V = 1'b0;
      default:
        for (int i = 0; i < 16; i++)
          if (mdl[i].V && mdl[i].TID == ent.TID && mdl[i].TS == ent.TS &&
              (mdl[i].TID != 8'h00 || ent.TID == 8'h00))
            mdl[i].V = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  int stall_run = 0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      stall_run = 0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", 128'(cycle_cnt), 128'(e[111:80]));
        check("rsp_data", {rsp_V, rsp_TS, rsp_TID, rsp_EPN, rsp_RPN, rsp_PERMIS}, 128'(e[79:0]));
        check("stall_cycles", 128'(stall_run), 128'(e[119:112]));
      end
      check("stall_in_done", 128'(lookup_stall), 128'(0));
      stall_run = 0;
    end else begin
      check("rsp_zero_idle", {rsp_V, rsp_TS, rsp_TID, rsp_EPN, rsp_RPN, rsp_PERMIS}, 128'(0));
      if (lookup_stall) stall_run++;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic issue(input logic [1:0] op, input int idx, input tlb_entry_t ent,
                       input bit keep, output int acc);
    tlb_entry_t rd;
    int lat;
    logic [7:0] st;
    req_op = op; req_index = 4'(idx);
    req_V = ent.V; req_TS = ent.TS; req_TID = ent.TID;
    req_EPN = ent.EPN; req_RPN = ent.RPN; req_PERMIS = ent.PERMIS;
    req_valid = 1'b1;
    for (int n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    check("accept_timeout", 128'(req_ready), 128'(1));
    if (!req_ready) begin
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cycle_cnt + 1;
    lat = op[1] ? 17 : 2;
    st  = op[1] ? 8'd16 : 8'd0;
    rd  = model_apply(op, idx, ent);
    exp_q.push_back({st, 32'(acc + lat - 1), rd});
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check("done_timeout", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      lk_index = 4'(i);
      #1;
      check($sformatf("%s_lookup[%0d]", tag, i),
            {TLB_entry_V, TLB_entry_TS, TLB_entry_TID, TLB_entry_EPN, TLB_entry_RPN,
             TLB_entry_PERMIS}, 128'(mdl[i]));
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a2;
    logic [3:0] v_exp;
    tlb_entry_t e;
    req_valid = 1'b0; req_op = 2'b00; req_index = '0; req_V = 1'b0; req_TS = 1'b0;
    req_TID = '0; req_EPN = '0; req_RPN = '0; req_PERMIS = '0; lk_index = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", 128'(req_ready), 128'(1));
    check("reset_done", 128'(done), 128'(0));
    check("reset_stall", 128'(lookup_stall), 128'(0));
    check("reset_state", 128'(dbg_state), 128'(ST_IDLE));
    check_all("reset");

    // single WRITE then READ of entry 5
    issue(2'b00, 5, mk(1'b1, 1'b0, 8'h12, 32'h0001_0000, 32'h2001_0000, 6'h2D), 1'b0, a0);
    wait_idle();
    check_all("write5");
    issue(2'b01, 5, '0, 1'b0, a0);
    wait_idle();

    // INV_PID on TID 0x12 with a global entry in between
    issue(2'b00, 0, mk(1'b1, 1'b0, 8'h12, 32'hA000, 32'hB000, 6'h3F), 1'b1, a0);
    issue(2'b00, 1, mk(1'b1, 1'b0, 8'h00, 32'hA001, 32'hB001, 6'h15), 1'b1, a0);
    issue(2'b00, 2, mk(1'b1, 1'b0, 8'h12, 32'hA002, 32'hB002, 6'h2A), 1'b1, a0);
    issue(2'b00, 3, mk(1'b1, 1'b0, 8'h34, 32'hA003, 32'hB003, 6'h07), 1'b0, a0);
    issue(2'b11, 0, mk(1'b0, 1'b0, 8'h12, 32'h0, 32'h0, 6'h0), 1'b0, a0);
    wait_idle();
    v_exp = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      lk_index = 4'(i);
      #1;
      check($sformatf("inv_pid_V[%0d]", i), 128'(TLB_entry_V), 128'(v_exp[i]));
      check($sformatf("inv_pid_EPN[%0d]", i), 128'(TLB_entry_EPN), 128'(32'hA000 + i));
    end
    @(negedge clk);
    check_all("inv_pid");

    // fill all, INV_ALL with a WRITE held pending through the sweep
    for (int i = 0; i < 16; i++) begin
      e = rnd_entry();
      e.V = 1'b1;
      issue(2'b00, i, e, 1'b1, a0);
    end
    issue(2'b10, 0, '0, 1'b1, a0);
    issue(2'b00, 9, mk(1'b1, 1'b1, 8'h55, 32'hC009, 32'hD009, 6'h11), 1'b0, a1);
    check("inv_all_hold_spacing", 128'(a1 - a0), 128'(18));
    wait_idle();
    check_all("inv_all");

    // back-to-back writes with req_valid held
    issue(2'b00, 3, mk(1'b1, 1'b0, 8'h21, 32'h3333, 32'h4444, 6'h09), 1'b1, a0);
    issue(2'b00, 7, mk(1'b1, 1'b1, 8'h22, 32'h7777, 32'h8888, 6'h24), 1'b1, a1);
    issue(2'b00, 11, mk(1'b1, 1'b0, 8'h23, 32'hBBBB, 32'hCCCC, 6'h12), 1'b0, a2);
    check("b2b_spacing_1", 128'(a1 - a0), 128'(3));
    check("b2b_spacing_2", 128'(a2 - a1), 128'(3));
    wait_idle();
    check_all("b2b");

    // reset in sweep cycle 7
    issue(2'b10, 0, '0, 1'b0, a0);
    for (int n = 0; n < 40 && cycle_cnt < a0 + 6; n++) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    check("mid_rst_ready", 128'(req_ready), 128'(1));
    check("mid_rst_stall", 128'(lookup_stall), 128'(0));
    check_all("mid_rst");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 128'(req_ready), 128'(1));
    issue(2'b00, 2, mk(1'b1, 1'b1, 8'h66, 32'h2222, 32'h9999, 6'h3C), 1'b0, a0);
    wait_idle();
    check_all("post_rst");

    // random traffic
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), rnd_entry(),
            (k != 59) && ($urandom_range(0, 1) == 1), a0);
    end
    wait_idle();
    check_all("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
